// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants and TX FSM state type.
// Bit positions follow the decoder's syndrome map (position p lives at index p-1).
package hamming_pkg;
   localparam int DATA_W = 4;
   localparam int CW_W   = 7;

   localparam int P1_IDX = 0;
   localparam int P2_IDX = 1;
   localparam int P4_IDX = 3;
   localparam int D_IDX [DATA_W] = '{2, 4, 5, 6};

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/hamming_encoder.sv
// Combinational Hamming(7,4) encoder; nibble bits scattered to data positions,
// parity bits at positions 1, 2 and 4.
module hamming_encoder
   import hamming_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CW_W-1:0]   cw
);

   always_comb begin
      cw = '0;
      for (int i = 0; i < DATA_W; i++) cw[D_IDX[i]] = data[i];
      cw[P1_IDX] = data[0] ^ data[1] ^ data[3];
      cw[P2_IDX] = data[0] ^ data[2] ^ data[3];
      cw[P4_IDX] = data[1] ^ data[2] ^ data[3];
   end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) encode + single-wire framed serializer with a one-entry pending buffer.
// Optional error injection on the wire only: define HAMMING_TX_ERR_INJECT_EN.
module hamming_tx_serializer
   import hamming_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              inj_en,
   input  logic [2:0]        inj_pos,
   output logic              tx_serial,
   output logic              busy,
   output logic [CW_W-1:0]   codeword_out,
   output logic              frame_done
);

   logic [CW_W-1:0] enc_cw;
   logic [CW_W-1:0] pend_cw;
   logic [CW_W-1:0] load_cw;
   logic [CW_W-1:0] frame_cw;
   logic            pend_full;
   logic            accept;
   logic            load;
   logic            cyc_end;
   logic            tx_nxt;
   tx_state_e       state, state_nxt;
   logic [7:0]      cyc_cnt, cyc_nxt, cyc_inc;
   logic [2:0]      bit_idx, bit_nxt;

   hamming_encoder u_enc (
      .data (in_data),
      .cw   (enc_cw)
   );

   assign in_ready = ~pend_full;
   assign accept   = in_valid && in_ready;
   assign cyc_end  = (cyc_cnt == 8'(BIT_CYCLES - 1));
   assign cyc_inc  = cyc_end ? 8'd0 : cyc_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_full <= 1'b0;
         pend_cw   <= '0;
      end else if (accept) begin
         pend_full <= 1'b1;
         pend_cw   <= enc_cw;
      end else if (load) begin
         pend_full <= 1'b0;
      end
   end

`ifdef HAMMING_TX_ERR_INJECT_EN
   // Flip mask travels with the pending codeword; codeword_out stays clean.
   logic [CW_W-1:0] pend_flip;
   logic [CW_W-1:0] tx_cw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_flip <= '0;
         tx_cw     <= '0;
      end else begin
         if (accept) pend_flip <= (inj_en && inj_pos != 3'd7) ? (CW_W'(1) << inj_pos) : '0;
         if (load)   tx_cw     <= load_cw;
      end
   end

   assign load_cw  = pend_cw ^ pend_flip;
   assign frame_cw = tx_cw;
`else
   logic unused_inj;
   assign unused_inj = ^{inj_en, inj_pos};
   assign load_cw    = pend_cw;
   assign frame_cw   = codeword_out;
`endif

   always_comb begin
      state_nxt = state;
      cyc_nxt   = '0;
      bit_nxt   = bit_idx;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (pend_full) begin
               load      = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            cyc_nxt = cyc_inc;
            if (cyc_end) begin
               state_nxt = DATA;
               bit_nxt   = 3'd0;
            end
         end
         DATA: begin
            cyc_nxt = cyc_inc;
            if (cyc_end) begin
               if (bit_idx == 3'(CW_W - 1)) state_nxt = STOP;
               else                         bit_nxt   = bit_idx + 3'd1;
            end
         end
         STOP: begin
            cyc_nxt = cyc_inc;
            // Back-to-back: reload straight into START with no idle gap.
            if (cyc_end) begin
               if (pend_full) begin
                  load      = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = frame_cw[bit_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cyc_cnt      <= '0;
         bit_idx      <= '0;
         tx_serial    <= 1'b1;
         codeword_out <= '0;
      end else begin
         state     <= state_nxt;
         cyc_cnt   <= cyc_nxt;
         bit_idx   <= bit_nxt;
         tx_serial <= tx_nxt;
         if (load) codeword_out <= pend_cw;
      end
   end

   assign busy       = (state != IDLE) || pend_full;
   assign frame_done = (state == STOP) && cyc_end;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: two instances (BIT_CYCLES 4 and 1), line traces
// compared against frames built from a position-based Hamming model.
module tb_hamming_tx_serializer;
   localparam int BC_A = 4;
   localparam int BC_B = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] in_data_a = '0, in_data_b = '0;
   logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic       inj_en_a = 1'b0, inj_en_b = 1'b0;
   logic [2:0] inj_pos_a = 3'd7, inj_pos_b = 3'd7;
   logic       in_ready_a, tx_a, busy_a, fd_a;
   logic       in_ready_b, tx_b, busy_b, fd_b;
   logic [6:0] cw_out_a, cw_out_b;

   int checks = 0;
   int errors = 0;
   int rec_sel = 0;
   int fd_cnt = 0;
   int fd_idx = -1;
   bit tr[$];
   bit exp_tr[$];
   logic [6:0] rx[$];
   logic [6:0] expq[$];

   typedef struct {
      logic [3:0] d;
      logic [6:0] cw;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   hamming_tx_serializer #(.BIT_CYCLES(BC_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .inj_en(inj_en_a), .inj_pos(inj_pos_a),
      .tx_serial(tx_a), .busy(busy_a), .codeword_out(cw_out_a), .frame_done(fd_a)
   );

   hamming_tx_serializer #(.BIT_CYCLES(BC_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .inj_en(inj_en_b), .inj_pos(inj_pos_b),
      .tx_serial(tx_b), .busy(busy_b), .codeword_out(cw_out_b), .frame_done(fd_b)
   );

   // Line recorder: one sample per cycle, away from the active edge.
   always @(negedge clk) begin
      if (rec_sel == 1) begin
         if (fd_a) begin fd_cnt++; fd_idx = tr.size(); end
         tr.push_back(tx_a);
      end else if (rec_sel == 2) begin
         if (fd_b) begin fd_cnt++; fd_idx = tr.size(); end
         tr.push_back(tx_b);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Hamming position model: data at positions 3,5,6,7; parity p covers positions with bit p set.
   function automatic logic [6:0] model_enc(input logic [3:0] d);
      int pos[4];
      logic [6:0] c;
      pos = '{3, 5, 6, 7};
      c = '0;
      for (int j = 0; j < 4; j++) begin
         c[pos[j]-1] = d[j];
         for (int k = 0; k < 3; k++)
            if ((pos[j] & (1 << k)) != 0) c[(1 << k) - 1] = c[(1 << k) - 1] ^ d[j];
      end
      return c;
   endfunction

   task automatic model_dec(input logic [6:0] c, output logic [3:0] d, output logic err);
      int pos[4];
      int syn;
      logic [6:0] f;
      pos = '{3, 5, 6, 7};
      syn = 0;
      f = c;
      for (int p = 1; p <= 7; p++) if (c[p-1]) syn = syn ^ p;
      if (syn != 0) f[syn-1] = ~f[syn-1];
      err = (syn != 0);
      for (int j = 0; j < 4; j++) d[j] = f[pos[j]-1];
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic add_frame(input int bc, input logic [6:0] c);
      repeat (bc) exp_tr.push_back(1'b0);
      for (int b = 0; b < 7; b++) repeat (bc) exp_tr.push_back(c[b]);
      repeat (bc) exp_tr.push_back(1'b1);
   endtask

   task automatic chk_trace(input string name);
      int bad;
      bad = -1;
      checks++;
      if (tr.size() < exp_tr.size()) bad = tr.size();
      else for (int i = 0; i < exp_tr.size(); i++) if (tr[i] !== exp_tr[i] && bad < 0) bad = i;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s line trace differs at sample %0d (got_len=%0d exp_len=%0d)",
                  name, bad, tr.size(), exp_tr.size());
      end
   endtask

   task automatic parse(input int bc);
      int i;
      logic [6:0] c;
      i = 0;
      rx.delete();
      while (i + 9*bc <= tr.size()) begin
         if (tr[i] == 1'b0) begin
            for (int b = 0; b < 7; b++) c[b] = tr[i + bc*(b+1) + bc/2];
            rx.push_back(c);
            i += 9*bc;
         end else begin
            i++;
         end
      end
   endtask

   task automatic start_rec(input int sel);
      tr.delete();
      exp_tr.delete();
      fd_cnt = 0;
      fd_idx = -1;
      rec_sel = sel;
   endtask

   task automatic wait_trace(input int n);
      int guard;
      guard = 0;
      while (tr.size() < n && guard < 3000) begin
         @(negedge clk); #1;
         guard++;
      end
      if (tr.size() < n) chk("wait_trace_timeout", tr.size(), n);
   endtask

   task automatic send(input int sel, input logic [3:0] d, input logic ie, input logic [2:0] ip);
      int guard;
      logic rdy;
      guard = 0;
      @(negedge clk);
      if (sel == 1) begin in_data_a = d; inj_en_a = ie; inj_pos_a = ip; in_valid_a = 1'b1; end
      else          begin in_data_b = d; inj_en_b = ie; inj_pos_b = ip; in_valid_b = 1'b1; end
      rdy = (sel == 1) ? in_ready_a : in_ready_b;
      while (!rdy && guard < 500) begin
         @(negedge clk);
         rdy = (sel == 1) ? in_ready_a : in_ready_b;
         guard++;
      end
      if (!rdy) chk("send_ready_timeout", 0, 1);
      else @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
   endtask

   task automatic chk_rx0(input string name, input logic [6:0] exp);
      if (rx.size() == 0) chk({name, "_no_frame"}, 0, 1);
      else chk(name, rx[0], exp);
   endtask

   initial begin
      logic [3:0] dd;
      logic       ee, exp_err, ie;
      logic [2:0] ip;
      logic [6:0] exp_inj, c;
      int         guard;

      tbl[0] = '{4'h0, 7'h00};
      tbl[1] = '{4'hF, 7'h7F};
      tbl[2] = '{4'h1, 7'h07};
      tbl[3] = '{4'hA, 7'h52};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", tx_a, 1);
      chk("rst_in_ready", in_ready_a, 1);
      chk("rst_busy", busy_a, 0);
      chk("rst_cw_out", cw_out_a, 0);
      chk("rst_frame_done", fd_a, 0);
      chk("rst_tx_b", tx_b, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single nibble 1011, BIT_CYCLES=4
      send(1, 4'b1011, 1'b0, 3'd7);
      start_rec(1);
      wait_trace(40);
      rec_sel = 0;
      exp_tr.push_back(1'b1);
      add_frame(BC_A, 7'h55);
      repeat (3) exp_tr.push_back(1'b1);
      chk_trace("frame_1011");
      chk("cw_out_1011", cw_out_a, 7'h55);
      chk("fd_count_1011", fd_cnt, 1);
      chk("fd_pos_1011", fd_idx, 36);
      chk("busy_after_1011", busy_a, 0);

      // Spot-value table on the BIT_CYCLES=4 instance
      for (int v = 0; v < 4; v++) begin
         send(1, tbl[v].d, 1'b0, 3'd7);
         start_rec(1);
         wait_trace(38);
         rec_sel = 0;
         parse(BC_A);
         chk($sformatf("tbl%0d_frames", v), rx.size(), 1);
         chk_rx0($sformatf("tbl%0d_line_cw", v), tbl[v].cw);
         chk($sformatf("tbl%0d_cw_out", v), cw_out_a, tbl[v].cw);
      end

      // Encode sweep through the BIT_CYCLES=1 instance, looped into a model decoder
      for (int v = 0; v < 16; v++) begin
         send(2, 4'(v), 1'b0, 3'd7);
         start_rec(2);
         wait_trace(11);
         rec_sel = 0;
         parse(BC_B);
         chk_rx0($sformatf("sweep%0d_cw", v), model_enc(4'(v)));
         c = (rx.size() > 0) ? rx[0] : 7'h00;
         model_dec(c, dd, ee);
         chk($sformatf("sweep%0d_dec", v), dd, v);
         chk($sformatf("sweep%0d_err", v), ee, 0);
      end

      // BIT_CYCLES=1, nibble A: 9-cycle frame one cycle after accept
      send(2, 4'hA, 1'b0, 3'd7);
      start_rec(2);
      wait_trace(12);
      rec_sel = 0;
      exp_tr.push_back(1'b1);
      add_frame(BC_B, 7'h52);
      repeat (2) exp_tr.push_back(1'b1);
      chk_trace("bc1_frame_A");
      chk("bc1_fd_pos", fd_idx, 9);
      chk("bc1_fd_count", fd_cnt, 1);

      // Back-to-back: second nibble offered the cycle after the first accept
      send(1, 4'h6, 1'b0, 3'd7);
      start_rec(1);
      send(1, 4'h9, 1'b0, 3'd7);
      chk("b2b_ready_low", in_ready_a, 0);
      chk("b2b_busy", busy_a, 1);
      wait_trace(76);
      rec_sel = 0;
      exp_tr.push_back(1'b1);
      add_frame(BC_A, model_enc(4'h6));
      add_frame(BC_A, model_enc(4'h9));
      repeat (3) exp_tr.push_back(1'b1);
      chk_trace("b2b_frames");
      chk("b2b_fd_count", fd_cnt, 2);
      chk("b2b_cw_out", cw_out_a, model_enc(4'h9));

      // Reset mid-DATA
      send(1, 4'hB, 1'b0, 3'd7);
      start_rec(1);
      wait_trace(12);
      rec_sel = 0;
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", tx_a, 1);
      chk("midrst_ready", in_ready_a, 1);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_fd", fd_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(1, 4'h3, 1'b0, 3'd7);
      start_rec(1);
      wait_trace(40);
      rec_sel = 0;
      exp_tr.push_back(1'b1);
      add_frame(BC_A, model_enc(4'h3));
      repeat (3) exp_tr.push_back(1'b1);
      chk_trace("post_rst_frame");
      chk("post_rst_fd", fd_cnt, 1);

      // Error injection (ignored when the feature is compiled out)
`ifdef HAMMING_TX_ERR_INJECT_EN
      exp_inj = 7'h45;
      exp_err = 1'b1;
`else
      exp_inj = 7'h55;
      exp_err = 1'b0;
`endif
      send(1, 4'b1011, 1'b1, 3'd4);
      start_rec(1);
      wait_trace(38);
      rec_sel = 0;
      parse(BC_A);
      chk_rx0("inj4_line_cw", exp_inj);
      c = (rx.size() > 0) ? rx[0] : 7'h00;
      model_dec(c, dd, ee);
      chk("inj4_dec", dd, 4'b1011);
      chk("inj4_err", ee, exp_err);
      chk("inj4_cw_out", cw_out_a, 7'h55);
      send(1, 4'b1011, 1'b1, 3'd7);
      start_rec(1);
      wait_trace(38);
      rec_sel = 0;
      parse(BC_A);
      chk_rx0("inj7_line_cw", 7'h55);

      // Randomized stream on BIT_CYCLES=1 with random gaps and injection requests
      expq.delete();
      start_rec(2);
      for (int n = 0; n < 24; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         dd = 4'($urandom);
         ie = 1'($urandom);
         ip = 3'($urandom);
         c = model_enc(dd);
`ifdef HAMMING_TX_ERR_INJECT_EN
         if (ie && ip != 3'd7) c[ip] = ~c[ip];
`endif
         expq.push_back(c);
         send(2, dd, ie, ip);
      end
      guard = 0;
      while (busy_b && guard < 2000) begin @(negedge clk); guard++; end
      chk("rand_idle", busy_b, 0);
      repeat (2) @(negedge clk);
      rec_sel = 0;
      parse(BC_B);
      chk("rand_frames", rx.size(), 24);
      chk("rand_fd_count", fd_cnt, 24);
      for (int i = 0; i < 24; i++) begin
         if (i < rx.size()) chk($sformatf("rand%0d_cw", i), rx[i], expq[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
